// File: rtl/countdown2.sv
// countdown2: two-digit loadable down-counter with borrow cascade and run control
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   enabled    - count tick, one decrement per sampled high cycle while running
//   load       - synchronous load strobe, highest priority after reset
//   load_low   - low digit to load (clamped to DIGIT_MAX)
//   load_high  - high digit to load (clamped to DIGIT_MAX)
//   start      - start or resume request (IDLE/PAUSE only)
//   stop       - pause request (RUN only), beats start
//   value_low  - registered low digit
//   value_high - registered high digit
//   running    - high while in RUN
//   done       - high while in DONE
//   expired    - one-cycle pulse on the RUN->DONE transition
module countdown2 #(
    parameter int DIGIT_MAX = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enabled,
    input  logic       load,
    input  logic [3:0] load_low,
    input  logic [3:0] load_high,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] value_low,
    output logic [3:0] value_high,
    output logic       running,
    output logic       done,
    output logic       expired
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [3:0] DMAX = 4'(DIGIT_MAX);

    state_t     state, state_nxt;
    logic [3:0] low_nxt, high_nxt;
    logic       expired_nxt;
    logic       is_zero;

    assign is_zero = value_low == 4'd0 && value_high == 4'd0;

    // running/done are registered alongside the state so they are glitch-free flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            value_low  <= 4'd0;
            value_high <= 4'd0;
            running    <= 1'b0;
            done       <= 1'b0;
            expired    <= 1'b0;
        end else begin
            state      <= state_nxt;
            value_low  <= low_nxt;
            value_high <= high_nxt;
            running    <= state_nxt == RUN;
            done       <= state_nxt == DONE;
            expired    <= expired_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        low_nxt     = value_low;
        high_nxt    = value_high;
        expired_nxt = 1'b0;
        if (load) begin
            low_nxt   = load_low > DMAX ? DMAX : load_low;
            high_nxt  = load_high > DMAX ? DMAX : load_high;
            state_nxt = IDLE;
        end else if (stop) begin
            // stop swallows a simultaneous start or tick in every state
            state_nxt = state == RUN ? PAUSE : state;
        end else if (start && (state == IDLE || state == PAUSE)) begin
            state_nxt = is_zero ? DONE : RUN;
        end else if (enabled && state == RUN && !is_zero) begin
            low_nxt  = value_low != 4'd0 ? value_low - 4'd1 : DMAX;
            high_nxt = value_low != 4'd0 ? value_high : value_high - 4'd1;
            if (value_high == 4'd0 && value_low == 4'd1) begin
                state_nxt   = DONE;
                expired_nxt = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_countdown2.sv
// tb_countdown2: directed self-checking bench for countdown2 (DIGIT_MAX 9 and 15)
module tb_countdown2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enabled = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_low = 4'd0;
    logic [3:0] load_high = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] lo9, hi9, lo15, hi15;
    logic       run9, done9, exp9, run15, done15, exp15;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_pulse = 0;
    logic [7:0] v9, f9, v15, f15, e;

    always #5 clk = ~clk;

    countdown2 #(.DIGIT_MAX(9)) u9 (
        .clk(clk), .rst_n(rst_n), .enabled(enabled), .load(load),
        .load_low(load_low), .load_high(load_high), .start(start), .stop(stop),
        .value_low(lo9), .value_high(hi9), .running(run9), .done(done9), .expired(exp9)
    );

    countdown2 #(.DIGIT_MAX(15)) u15 (
        .clk(clk), .rst_n(rst_n), .enabled(enabled), .load(load),
        .load_low(load_low), .load_high(load_high), .start(start), .stop(stop),
        .value_low(lo15), .value_high(hi15), .running(run15), .done(done15), .expired(exp15)
    );

    // value as {high,low}; flags as {running,done,expired}
    assign v9  = {hi9, lo9};
    assign f9  = {5'd0, run9, done9, exp9};
    assign v15 = {hi15, lo15};
    assign f15 = {5'd0, run15, done15, exp15};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] l, input logic [3:0] h);
        load = 1'b1; load_low = l; load_high = h;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #3;
        check("reset_value", v9, 8'h00);
        check("reset_flags", f9, 8'h0);
        #4 rst_n = 1'b1;
        tick();
        // full countdown 23 -> 00
        do_load(4'd3, 4'd2);
        check("load23_value", v9, 8'h23);
        check("load23_flags", f9, 8'h0);
        enabled = 1'b1;
        do_start();
        check("start_no_count", v9, 8'h23);
        check("start_running", f9, 8'h4);
        for (int i = 22; i >= 0; i--) begin
            tick();
            e = 8'((i / 10) * 16 + i % 10);
            check("count_value", v9, e);
            if (exp9) n_pulse++;
            check("count_flags", f9, i == 0 ? 8'h3 : 8'h4);
        end
        tick();
        check("hold_at_00", v9, 8'h00);
        check("done_after", f9, 8'h2);
        check("one_pulse", 8'(n_pulse), 8'd1);
        enabled = 1'b0;
        // borrow boundary
        do_load(4'd0, 4'd1);
        do_start();
        enabled = 1'b1;
        tick();
        enabled = 1'b0;
        check("borrow9", v9, 8'h09);
        check("borrow15", v15, 8'h0F);
        check("borrow15_run", f15, 8'h4);
        // clamp
        do_load(4'd14, 4'd12);
        check("clamp9", v9, 8'h99);
        check("clamp15", v15, 8'hCE);
        // pause / resume
        do_load(4'd5, 4'd1);
        do_start();
        check("run15_value", v9, 8'h15);
        stop = 1'b1; enabled = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_value", v9, 8'h15);
        check("stop_flags", f9, 8'h0);
        for (int i = 0; i < 10; i++) tick();
        check("pause_hold", v9, 8'h15);
        do_start();
        check("resume_no_count", v9, 8'h15);
        check("resume_run", f9, 8'h4);
        for (int i = 0; i < 3; i++) tick();
        enabled = 1'b0;
        check("resume_value", v9, 8'h12);
        // start+stop together in IDLE
        do_load(4'd5, 4'd0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("startstop_flags", f9, 8'h0);
        check("startstop_value", v9, 8'h05);
        // load during RUN
        do_load(4'd7, 4'd0);
        do_start();
        check("run07", f9, 8'h4);
        enabled = 1'b1; start = 1'b1;
        do_load(4'd2, 4'd4);
        start = 1'b0;
        check("reload_value", v9, 8'h42);
        check("reload_flags", f9, 8'h0);
        tick();
        check("reload_hold", v9, 8'h42);
        check("reload_idle", f9, 8'h0);
        enabled = 1'b0;
        // start at 00
        do_load(4'd0, 4'd0);
        do_start();
        check("start00_flags", f9, 8'h2);
        check("start00_value", v9, 8'h00);
        // asynchronous reset mid-count
        do_load(4'd1, 4'd3);
        do_start();
        enabled = 1'b1;
        check("pre_reset", f9, 8'h4);
        #2 rst_n = 1'b0;
        #1;
        check("async_value", v9, 8'h00);
        check("async_flags", f9, 8'h0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("post_reset_value", v9, 8'h00);
        check("post_reset_flags", f9, 8'h0);
        enabled = 1'b0;
        do_load(4'd2, 4'd0);
        do_start();
        enabled = 1'b1;
        tick();
        enabled = 1'b0;
        check("rerun_value", v9, 8'h01);
        check("rerun_flags", f9, 8'h4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
